// File: rtl/uart_rx_ctrl_if.sv
// Serial-side and status signals between the UART RX controller and its surroundings.
// The slave modport is the controller's view; the master modport is the line/CPU side.
interface uart_rx_ctrl_if;
   logic Rx;
   logic clr_frm_err;
   logic rx_sync;
   logic shift;
   logic load_buffer;
   logic busy;
   logic framing_err;

   modport master (
      output Rx,
      output clr_frm_err,
      input  rx_sync,
      input  shift,
      input  load_buffer,
      input  busy,
      input  framing_err
   );

   modport slave (
      input  Rx,
      input  clr_frm_err,
      output rx_sync,
      output shift,
      output load_buffer,
      output busy,
      output framing_err
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive timing/control FSM: synchronises Rx, finds the start bit and issues
// mid-bit shift / load_buffer strobes to the downstream 8-bit shift/buffer register.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic          CLOCK,
   input  logic          reset,
   uart_rx_ctrl_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_TERM  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic          sync_a_r;
   logic          sync_b_r;
   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic [2:0]    idx_r;
   logic [2:0]    idx_s;
   logic          shift_r;
   logic          shift_s;
   logic          load_r;
   logic          load_s;
   logic          busy_r;
   logic          ferr_r;
   logic          ferr_set_s;

   // Two-flop synchroniser on the raw line; reset to the idle (high) level.
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         sync_a_r <= 1'b1;
         sync_b_r <= 1'b1;
      end else begin
         sync_a_r <= bus.Rx;
         sync_b_r <= sync_a_r;
      end
   end

   // Next-state, counter and strobe decode; every decision looks at the synchronised bit.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      idx_s      = idx_r;
      shift_s    = 1'b0;
      load_s     = 1'b0;
      ferr_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = CNT_ZERO;
            idx_s = 3'd0;
            if (!sync_b_r) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            // A start bit that is high again at its midpoint was only a glitch.
            if (cnt_r == HALF_TERM) begin
               cnt_s = CNT_ZERO;
               if (!sync_b_r) begin
                  state_s = DATA;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == BIT_TERM) begin
               shift_s = 1'b1;
               cnt_s   = CNT_ZERO;
               idx_s   = idx_r + 3'd1;
               if (idx_r == LAST_IDX) begin
                  state_s = STOP;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_r == BIT_TERM) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE;
               if (sync_b_r) begin
                  load_s = 1'b1;
               end else begin
                  ferr_set_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            idx_s   = 3'd0;
         end
      endcase
   end

   // State, counters and registered outputs; a set of framing_err beats a same-cycle clear.
   always_ff @(posedge CLOCK) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 1'b0;
         load_r  <= 1'b0;
         busy_r  <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         load_r  <= load_s;
         busy_r  <= (state_s != IDLE);
         if (ferr_set_s) begin
            ferr_r <= 1'b1;
         end else if (bus.clr_frm_err) begin
            ferr_r <= 1'b0;
         end else begin
            ferr_r <= ferr_r;
         end
      end
   end

   assign bus.rx_sync     = sync_b_r;
   assign bus.shift       = shift_r;
   assign bus.load_buffer = load_r;
   assign bus.busy        = busy_r;
   assign bus.framing_err = ferr_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are turned into expected strobe events
// (bit value and timing from the frame rules) and a per-instance monitor checks them.
module tb_uart_rx_ctrl;
   localparam int CPB_A = 16;
   localparam int CPB_B = 434;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   uart_rx_ctrl_if ifa ();
   uart_rx_ctrl_if ifb ();

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dut_a (.CLOCK(clk), .reset(rst_a), .bus(ifa.slave));
   uart_rx_ctrl #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dut_b (.CLOCK(clk), .reset(rst_b), .bus(ifb.slave));

   // kind: 0 = shift, 1 = load_buffer, 2 = framing_err rise
   typedef struct {
      int     kind;
      int     bitv;
      longint t;
      int     tol;
      bit     rel;
   } exp_t;

   exp_t   qa[$];
   exp_t   qb[$];
   longint loads_a[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   // Shifts after the first, and the end-of-frame event, are timed from the previous shift.
   function automatic void cmp(string nm, exp_t e, int kind, int bitv, longint now, longint last_t, int cpb);
      longint ref_t;
      longint diff;
      ref_t = e.rel ? last_t + longint'(cpb) : e.t;
      diff  = now - ref_t;
      checks++;
      if (e.kind != kind || (kind == 0 && e.bitv != bitv) || diff > longint'(e.tol) || diff < -longint'(e.tol)) begin
         errors++;
         $display("FAIL %s: got kind=%0d bit=%0d t=%0d, expected kind=%0d bit=%0d t=%0d+-%0d",
                  nm, kind, bitv, now, e.kind, e.bitv, ref_t, e.tol);
      end
   endfunction

   function automatic void unexpected(string nm);
      checks++;
      errors++;
      $display("FAIL %s: unexpected strobe at cycle %0d, expected none", nm, cyc);
   endfunction

   logic   ferr_prev_a = 1'b0;
   logic   ferr_prev_b = 1'b0;
   longint last_a = 0;
   longint last_b = 0;

   // Monitor for instance A: every strobe or framing_err rise consumes one expected event.
   always @(negedge clk) begin
      if (rst_a) begin
         ferr_prev_a <= 1'b0;
      end else begin
         if (ifa.shift && ifa.load_buffer) unexpected("a_shift_and_load");
         if (ifa.shift) begin
            if (qa.size() == 0) unexpected("a_shift");
            else cmp("a_shift", qa.pop_front(), 0, int'(ifa.rx_sync), cyc, last_a, CPB_A);
            last_a <= cyc;
         end
         if (ifa.load_buffer) begin
            if (qa.size() == 0) unexpected("a_load");
            else cmp("a_load", qa.pop_front(), 1, 0, cyc, last_a, CPB_A);
            loads_a.push_back(cyc);
         end
         if (ifa.framing_err && !ferr_prev_a) begin
            if (qa.size() == 0) unexpected("a_ferr");
            else cmp("a_ferr", qa.pop_front(), 2, 0, cyc, last_a, CPB_A);
         end
         ferr_prev_a <= ifa.framing_err;
      end
   end

   // Monitor for instance B (full-size bit period).
   always @(negedge clk) begin
      if (rst_b) begin
         ferr_prev_b <= 1'b0;
      end else begin
         if (ifb.shift && ifb.load_buffer) unexpected("b_shift_and_load");
         if (ifb.shift) begin
            if (qb.size() == 0) unexpected("b_shift");
            else cmp("b_shift", qb.pop_front(), 0, int'(ifb.rx_sync), cyc, last_b, CPB_B);
            last_b <= cyc;
         end
         if (ifb.load_buffer) begin
            if (qb.size() == 0) unexpected("b_load");
            else cmp("b_load", qb.pop_front(), 1, 0, cyc, last_b, CPB_B);
         end
         if (ifb.framing_err && !ferr_prev_b) begin
            if (qb.size() == 0) unexpected("b_ferr");
            else cmp("b_ferr", qb.pop_front(), 2, 0, cyc, last_b, CPB_B);
         end
         ferr_prev_b <= ifb.framing_err;
      end
   end

   // Reference model: LSB-first data sampled mid-bit, first shift 2+HALF+CPB after the fall.
   task automatic push_frame(input int inst, input longint t0, input logic [7:0] d,
                             input bit stop, input int nbits, input int cpb);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         e.kind = 0;
         e.bitv = int'(d[i]);
         e.t    = t0 + 2 + cpb / 2 + cpb;
         e.tol  = (i == 0) ? 1 : 0;
         e.rel  = (i != 0);
         if (inst == 0) qa.push_back(e); else qb.push_back(e);
      end
      if (nbits == 8) begin
         e.kind = stop ? 1 : 2;
         e.bitv = 0;
         e.t    = 0;
         e.tol  = stop ? 0 : 1;
         e.rel  = 1'b1;
         if (inst == 0) qa.push_back(e); else qb.push_back(e);
      end
   endtask

   task automatic set_rx(input int inst, input logic v);
      if (inst == 0) ifa.Rx = v; else ifb.Rx = v;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives start + nbits data (+ stop when nbits==8); call just after a rising edge.
   // clr_hold keeps clr_frm_err high through the stop bit until framing_err is seen set.
   task automatic send(input int inst, input logic [7:0] d, input bit stop, input int nbits, input bit clr_hold);
      int cpb;
      cpb = (inst == 0) ? CPB_A : CPB_B;
      push_frame(inst, cyc, d, stop, nbits, cpb);
      set_rx(inst, 1'b0);
      wait_cyc(cpb);
      chk("busy_in_frame", (inst == 0) ? int'(ifa.busy) : int'(ifb.busy), 1);
      for (int i = 0; i < nbits; i++) begin
         set_rx(inst, d[i]);
         wait_cyc(cpb);
      end
      if (nbits == 8) begin
         set_rx(inst, stop);
         if (clr_hold) ifa.clr_frm_err = 1'b1;
         for (int c = 0; c < cpb; c++) begin
            @(negedge clk);
            if (clr_hold && ifa.framing_err) ifa.clr_frm_err = 1'b0;
            @(posedge clk);
            #1;
         end
         ifa.clr_frm_err = 1'b0;
         set_rx(inst, 1'b1);
      end
   endtask

   task automatic pulse_clr();
      ifa.clr_frm_err = 1'b1;
      wait_cyc(1);
      ifa.clr_frm_err = 1'b0;
      chk("ferr_cleared", int'(ifa.framing_err), 0);
   endtask

   initial begin
      int        busy_cnt;
      logic [7:0] d;
      bit        stop;
      ifa.Rx = 1'b1; ifa.clr_frm_err = 1'b0;
      ifb.Rx = 1'b1; ifb.clr_frm_err = 1'b0;
      rst_a = 1'b1;  rst_b = 1'b1;
      wait_cyc(3);
      rst_a = 1'b0;  rst_b = 1'b0;

      chk("rst_rx_sync", int'(ifa.rx_sync), 1);
      chk("rst_shift", int'(ifa.shift), 0);
      chk("rst_load", int'(ifa.load_buffer), 0);
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_ferr", int'(ifa.framing_err), 0);
      chk("rst_b_busy", int'(ifb.busy), 0);
      wait_cyc(4);

      // Plain frame
      send(0, 8'hA5, 1'b1, 8, 1'b0);
      chk("a5_ferr", int'(ifa.framing_err), 0);
      wait_cyc(10);

      // Short glitch on the line must be rejected at mid-start
      set_rx(0, 1'b0);
      wait_cyc(4);
      set_rx(0, 1'b1);
      busy_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ifa.busy) busy_cnt++;
      end
      wait_cyc(1);
      checks++;
      if (busy_cnt < 6 || busy_cnt > 10) begin
         errors++;
         $display("FAIL glitch_busy_len: got %0d cycles, expected 6..10", busy_cnt);
      end
      chk("glitch_busy_low", int'(ifa.busy), 0);

      // Framing error: sticky, cleared by pulse; set wins over a simultaneous clear
      send(0, 8'h3C, 1'b0, 8, 1'b0);
      chk("ferr_set", int'(ifa.framing_err), 1);
      wait_cyc(20);
      chk("ferr_held", int'(ifa.framing_err), 1);
      pulse_clr();
      wait_cyc(CPB_A);
      send(0, 8'(($urandom)), 1'b0, 8, 1'b1);
      chk("ferr_set_wins", int'(ifa.framing_err), 1);
      wait_cyc(5);
      chk("ferr_set_wins_held", int'(ifa.framing_err), 1);
      pulse_clr();
      wait_cyc(CPB_A);

      // Back-to-back frames, no idle gap
      send(0, 8'h00, 1'b1, 8, 1'b0);
      send(0, 8'hFF, 1'b1, 8, 1'b0);
      wait_cyc(4);
      checks++;
      if (loads_a.size() < 2 || loads_a[loads_a.size()-1] - loads_a[loads_a.size()-2] < 159 ||
          loads_a[loads_a.size()-1] - loads_a[loads_a.size()-2] > 161) begin
         errors++;
         $display("FAIL b2b_load_spacing: got %0d loads, last spacing %0d, expected 160+-1", loads_a.size(),
                  (loads_a.size() < 2) ? 0 : loads_a[loads_a.size()-1] - loads_a[loads_a.size()-2]);
      end

      // Reset in the middle of DATA, after the third shift
      send(0, 8'(($urandom)), 1'b1, 3, 1'b0);
      set_rx(0, 1'b1);
      rst_a = 1'b1;
      wait_cyc(1);
      rst_a = 1'b0;
      chk("midrst_busy", int'(ifa.busy), 0);
      chk("midrst_shift", int'(ifa.shift), 0);
      chk("midrst_load", int'(ifa.load_buffer), 0);
      wait_cyc(2);
      chk("midrst_rx_sync", int'(ifa.rx_sync), 1);
      wait_cyc(200);
      send(0, 8'h81, 1'b1, 8, 1'b0);
      wait_cyc(3);

      // Randomised frames, occasional bad stop bits
      for (int n = 0; n < 10; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send(0, d, stop, 8, 1'b0);
         if (!stop) begin
            chk("rand_ferr", int'(ifa.framing_err), 1);
            pulse_clr();
            wait_cyc(CPB_A + $urandom_range(0, 8));
         end else begin
            wait_cyc($urandom_range(0, 5));
         end
      end

      // Full-size bit period instance
      send(1, 8'h55, 1'b1, 8, 1'b0);
      chk("b_ferr", int'(ifb.framing_err), 0);

      for (int c = 0; c < 2000 && (qa.size() != 0 || qb.size() != 0); c++) @(posedge clk);
      wait_cyc(2);
      chk("pending_events", qa.size() + qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
